// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if: handshake and data bundle between the weight ROM /
// window source (master) and the convolution MAC engine (slave).
interface conv_mac_engine_if #(
    parameter int unsigned INPUT_CHANNELS = 3,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WEIGHT_WIDTH   = 8
);
    localparam int unsigned N         = INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned ACC_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + $clog2(N) + 1;

    logic                          start;
    logic                          weight_read_en;
    logic [N*WEIGHT_WIDTH-1:0]     weight_in;
    logic                          weight_valid;
    logic [N*DATA_WIDTH-1:0]       window_in;
    logic                          window_valid;
    logic                          ready;
    logic signed [ACC_WIDTH-1:0]   conv_out;
    logic                          conv_valid;

    modport master (
        output start, weight_in, weight_valid, window_in, window_valid,
        input  weight_read_en, ready, conv_out, conv_valid
    );

    modport slave (
        input  start, weight_in, weight_valid, window_in, window_valid,
        output weight_read_en, ready, conv_out, conv_valid
    );
endinterface

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: single-filter convolution MAC stage.
// Fetches the filter's packed weights from the ROM, then produces one signed
// dot-product-plus-bias per accepted window through a 3-stage pipeline
// (products -> per-channel sums -> channel sum + bias).
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
module conv_mac_engine #(
    parameter int unsigned INPUT_CHANNELS = 3,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WEIGHT_WIDTH   = 8,
    parameter int          BIAS           = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_mac_engine_if.slave bus
);
    localparam int unsigned KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned N          = INPUT_CHANNELS * KK;
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned ACC_WIDTH  = PROD_WIDTH + $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                        state_q;
    logic                          weight_read_en_q;
    logic                          ready_q;
    logic [N*WEIGHT_WIDTH-1:0]     weights_q;

    logic signed [PROD_WIDTH-1:0]  prod_d [N];
    logic signed [PROD_WIDTH-1:0]  prod_q [N];
    logic                          s1_valid_q;
    logic signed [ACC_WIDTH-1:0]   chan_d [INPUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]   chan_q [INPUT_CHANNELS];
    logic                          s2_valid_q;
    logic signed [ACC_WIDTH-1:0]   sum_d;
    logic signed [ACC_WIDTH-1:0]   conv_d;
    logic signed [ACC_WIDTH-1:0]   conv_out_q;
    logic                          conv_valid_q;

    logic                          accept_c;

    // A window enters the pipeline only while the engine advertises ready.
    assign accept_c = ready_q & bus.window_valid;

    // Control FSM: weight fetch, streaming, and drain before a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            weight_read_en_q <= 1'b0;
            ready_q          <= 1'b0;
            weights_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q          <= LOAD;
                        weight_read_en_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.weight_valid) begin
                        weights_q        <= bus.weight_in;
                        weight_read_en_q <= 1'b0;
                        ready_q          <= 1'b1;
                        state_q          <= RUN;
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        ready_q <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // S3 drains on its own; only the first two stages gate the reload.
                    if (!s1_valid_q && !s2_valid_q) begin
                        weight_read_en_q <= 1'b1;
                        state_q          <= LOAD;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    weight_read_en_q <= 1'b0;
                    ready_q          <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 operands: element-wise signed products of window and weights.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            prod_d[i] = PROD_WIDTH'($signed(bus.window_in[i*DATA_WIDTH +: DATA_WIDTH]))
                      * PROD_WIDTH'($signed(weights_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    end

    // Stage 2 operands: one full-precision sum per input channel.
    always_comb begin
        for (int c = 0; c < int'(INPUT_CHANNELS); c++) begin
            chan_d[c] = '0;
            for (int k = 0; k < int'(KK); k++) begin
                chan_d[c] = chan_d[c] + ACC_WIDTH'(prod_q[c*KK + k]);
            end
        end
    end

    // Stage 3 operand: channel total plus bias, optionally rectified.
    always_comb begin
        sum_d = ACC_WIDTH'(BIAS);
        for (int c = 0; c < int'(INPUT_CHANNELS); c++) begin
            sum_d = sum_d + chan_q[c];
        end
`ifdef CONV_RELU_EN
        conv_d = sum_d[ACC_WIDTH-1] ? '0 : sum_d;
`else
        conv_d = sum_d;
`endif
    end

    // Pipeline registers; data only moves with its valid bit so conv_out holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                prod_q[i] <= '0;
            end
            for (int c = 0; c < int'(INPUT_CHANNELS); c++) begin
                chan_q[c] <= '0;
            end
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            conv_out_q   <= '0;
            conv_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= accept_c;
            s2_valid_q   <= s1_valid_q;
            conv_valid_q <= s2_valid_q;
            if (accept_c) begin
                for (int i = 0; i < int'(N); i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (s1_valid_q) begin
                for (int c = 0; c < int'(INPUT_CHANNELS); c++) begin
                    chan_q[c] <= chan_d[c];
                end
            end
            if (s2_valid_q) begin
                conv_out_q <= conv_d;
            end
        end
    end

    assign bus.weight_read_en = weight_read_en_q;
    assign bus.ready          = ready_q;
    assign bus.conv_out       = conv_out_q;
    assign bus.conv_valid     = conv_valid_q;

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Single-filter convolution MAC stage placed directly downstream of the per-filter parallel weight ROM. It requests the filter's packed multi-channel weights over the ROM's read-enable/valid handshake and holds them in a local register. It then accepts one packed multi-channel window per cycle and produces one signed dot-product-plus-bias result per window through a 3-stage pipeline.

## Interface
- INPUT_CHANNELS, 3, channels per window/filter
- KERNEL_SIZE, 3, kernel edge length
- DATA_WIDTH, 8, signed pixel width
- WEIGHT_WIDTH, 8, signed weight width
- BIAS, 0, signed filter bias added to every result (ACC_WIDTH bits)
- Derived: N = INPUT_CHANNELS·KERNEL_SIZE², ACC_WIDTH = DATA_WIDTH+WEIGHT_WIDTH+$clog2(N)+1

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: (re)load weights
- weight_read_en  out  1  to ROM read_enable
- weight_in  in  N·WEIGHT_WIDTH  packed weights from ROM
- weight_valid  in  1  ROM weight_valid
- window_in  in  N·DATA_WIDTH  packed window
- window_valid  in  1  window present this cycle
- ready  out  1  engine accepts windows
- conv_out  out  ACC_WIDTH  signed result
- conv_valid  out  1  conv_out valid, single-cycle per result

## Operation
- Packing (weights and window): element i = c·K² + r·K + col at bits [(i+1)·W-1 -: W]; all elements two's complement.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE: weight_read_en=0, ready=0. start → LOAD.
  - LOAD: weight_read_en=1. weight_valid=1 → latch weight_in into weight register, drop weight_read_en, → RUN.
  - RUN: ready=1. window_valid=1 → window enters pipeline. start → DRAIN (the window presented in the same cycle is still accepted).
  - DRAIN: ready=0, weight_read_en=0; when all pipeline valid bits are 0 → LOAD.
- start in LOAD or DRAIN ignored. window_valid with ready=0 ignored (no result).
- Pipeline: S1 registers N signed products (DATA_WIDTH+WEIGHT_WIDTH bits each); S2 registers INPUT_CHANNELS per-channel sums; S3 sums channels, adds sign-extended BIAS, registers conv_out. Full-precision; no saturation or rounding.
- Weight register holds its value through RUN/DRAIN; replaced only on LOAD completion.

## Timing
- Reset: state=IDLE, weight_read_en=0, ready=0, conv_out=0, conv_valid=0, weight register=0, pipeline valid bits=0.
- start sampled at edge t → weight_read_en high after t.
- weight_valid sampled at edge u → RUN, ready and weight_read_en=0 after u (ROM valid drops one cycle later).
- Latency: window accepted at edge n → conv_valid=1 with its result after edge n+3; throughput 1 per cycle; results in acceptance order.
- conv_out holds the last value when conv_valid=0.
- DRAIN lasts ≤3 cycles; weight_read_en rises the cycle after pipeline empties.
- Reset asserted mid-operation: everything returns to reset values immediately; in-flight results discarded, no conv_valid.

## Configuration
- CONV_RELU_EN defined: S3 output clamped — negative sum → conv_out=0; non-negative unchanged. Latency unchanged.
- Undefined: conv_out is the raw signed sum.

## Test plan
- Reset/load: release rst_n, pulse start; ROM model returns weight_valid after 28 cycles with all weights=1 → weight_read_en high 28 cycles then low, ready=1 next cycle.
- Single window: weights all 1, BIAS=5, window all 2 (N=27) → conv_out=59, conv_valid exactly 3 cycles after acceptance.
- Signed/back-to-back: weights all -1, windows of all 127 then all -128 on consecutive cycles → conv_out=-3429 then 3456 on consecutive cycles (with CONV_RELU_EN: 0 then 3456).
- Reload mid-stream: start in the same cycle as a valid window → that window's result emitted, ready=0 during DRAIN, then new load; windows presented while ready=0 produce no conv_valid.
- Async reset during RUN with 3 windows in flight → conv_valid never asserts, all outputs 0, state IDLE.
- Ignored start: pulse start during LOAD → single load completes, no second ROM request.
